// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder with its own control FSM. An accepted start captures
//   the operands. One full adder then adds them one bit per clock, LSB first,
//   over WIDTH clocks. The result is registered and a one-cycle done pulse
//   follows.
//
// Parameters
//   WIDTH  operand/result width and number of serial steps (must be >= 2)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all state and outputs
//   start  request a new addition (accepted only in IDLE)
//   abort  synchronous cancel while shifting (ignored in IDLE and DONE)
//   a, b   operands, captured on the start-accepting edge only
//   busy   high whenever the FSM is not in IDLE
//   done   one-cycle completion pulse
//   sum    result of the last completed addition
//   cout   carry-out of the last completed addition
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] count;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] a_next;

    // One-bit full adder: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    // The sum bit enters at the MSB of A. After WIDTH shifts, A holds the
    // complete result and the operand bits have all been consumed.
    always_comb begin
        {fa_carry, fa_sum} = full_add(a_sr[0], b_sr[0], carry);
        a_next             = {fa_sum, a_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        count <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end

                SHIFT: begin
                    // abort wins over the terminal step: no result, no done
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        a_sr  <= a_next;
                        b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                        carry <= fa_carry;
                        count <= count + CNT_W'(1);
                        if (count == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                            sum   <= a_next;
                            cout  <= fa_carry;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl with WIDTH=4 and WIDTH=8
//   instances. It applies table-driven directed vectors, hand-written corner
//   sequences and randomized traffic. The randomized traffic is checked
//   against a transaction-level reference model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start4, abort4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    logic       start8, abort8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       c;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic st, input logic ab,
                         input logic [7:0] av, input logic [7:0] bv);
        if (w == 4) begin
            start4 = st; abort4 = ab; a4 = av[3:0]; b4 = bv[3:0];
        end else begin
            start8 = st; abort8 = ab; a8 = av; b8 = bv;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One complete WIDTH=4 addition, with latency, busy-length and result checks.
    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic ab,
                           input logic [3:0] es, input logic ec, input string nm);
        int lat;
        int bcnt;
        a4 = av; b4 = bv; start4 = 1'b1; abort4 = ab;
        tick();
        start4 = 1'b0; abort4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        lat  = 1;
        bcnt = busy4 ? 1 : 0;
        while (!done4 && lat < 20) begin
            tick();
            lat++;
            if (busy4) bcnt++;
            a4 = 4'($urandom); b4 = 4'($urandom);
        end
        check({nm, "_latency"}, lat, 5);
        check({nm, "_busy_cycles"}, bcnt, 5);
        check({nm, "_sum"}, sum4, es);
        check({nm, "_cout"}, cout4, ec);
        tick();
        check({nm, "_back_idle"}, {busy4, done4}, 2'b00);
    endtask

    // Randomized traffic against a transaction-level model. The model tracks
    // edges elapsed since acceptance (t). t=1..w is the shifting phase.
    // t=w+1 is the done cycle. t=0 is idle.
    task automatic rand_run(input int w, input int nops, input bit use_abort);
        int         t;
        int         accepted;
        int         completed;
        int         dones;
        int         cyc;
        logic [8:0] pend;
        logic [8:0] exp_res;
        logic [8:0] act;
        logic       st, ab, bz, dn;
        logic [7:0] av, bv;
        t = 0; accepted = 0; completed = 0; dones = 0; cyc = 0;
        pend = '0; exp_res = '0;
        while ((accepted < nops || t != 0) && cyc < 20000) begin
            st = (accepted < nops) && ($urandom_range(0, 2) == 0);
            ab = use_abort && ($urandom_range(0, 9) == 0);
            av = (w == 4) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            bv = (w == 4) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            drive(w, st, ab, av, bv);
            if (t == 0) begin
                if (st) begin
                    t = 1;
                    pend = 9'(av) + 9'(bv);
                    accepted++;
                end
            end else if (t <= w) begin
                if (ab) t = 0;
                else if (t == w) begin
                    t = w + 1;
                    exp_res = pend;
                    completed++;
                end else t++;
            end else begin
                t = 0;
            end
            tick();
            cyc++;
            if (w == 4) begin
                act = {4'b0, cout4, sum4}; bz = busy4; dn = done4;
            end else begin
                act = {cout8, sum8}; bz = busy8; dn = done8;
            end
            if (dn) dones++;
            check("rand_busy", bz, (t != 0));
            check("rand_done", dn, (t == w + 1));
            check("rand_result", act, exp_res);
        end
        drive(w, 1'b0, 1'b0, 8'd0, 8'd0);
        check("rand_finished_in_budget", (cyc < 20000), 1'b1);
        check("rand_done_vs_completed", dones, completed);
        if (!use_abort) check("rand_done_vs_accepted", dones, accepted);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ndone;

        tbl[0] = '{4'h9, 4'h7, 4'h0, 1'b1};
        tbl[1] = '{4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2] = '{4'hF, 4'hF, 4'hE, 1'b1};
        tbl[3] = '{4'h5, 4'h2, 4'h7, 1'b0};
        tbl[4] = '{4'hF, 4'h1, 4'h0, 1'b1};
        tbl[5] = '{4'h6, 4'h3, 4'h9, 1'b0};
        tbl[6] = '{4'hA, 4'h5, 4'hF, 1'b0};

        rst_n = 1'b0;
        drive(4, 1'b0, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 1'b0, 8'd0, 8'd0);
        tick();
        tick();
        check("reset4_outputs", {busy4, done4, cout4, sum4}, '0);
        check("reset8_outputs", {busy8, done8, cout8, sum8}, '0);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {busy4, done4}, 2'b00);

        // Directed vectors
        for (int i = 0; i < 7; i++)
            run_op4(tbl[i].a, tbl[i].b, 1'b0, tbl[i].s, tbl[i].c, $sformatf("vec%0d", i));

        // Back-to-back with start held high
        a4 = 4'h5; b4 = 4'h2; start4 = 1'b1;
        tick();
        a4 = 4'hF; b4 = 4'h1;
        k = 1;
        while (!done4 && k < 20) begin tick(); k++; end
        check("b2b_first_latency", k, 5);
        check("b2b_first_sum", {cout4, sum4}, 5'b0_0111);
        tick();
        check("b2b_idle_gap_busy", busy4, 1'b0);
        tick();
        check("b2b_second_accept", busy4, 1'b1);
        start4 = 1'b0;
        k = 1;
        while (!done4 && k < 20) begin tick(); k++; end
        check("b2b_second_latency", k, 5);
        check("b2b_second_sum", {cout4, sum4}, 5'b1_0000);
        tick();

        // Start pulses during SHIFT and DONE are ignored
        a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
        tick();
        a4 = 4'h0; b4 = 4'h0;
        tick();
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 10) begin tick(); k++; end
        check("ign_latency", k, 3);
        check("ign_sum", {cout4, sum4}, 5'b0_1000);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ign_done_edge_busy", {busy4, done4}, 2'b00);
        ndone = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done4 || busy4) ndone++;
        end
        check("ign_no_extra_activity", ndone, 0);
        check("ign_sum_hold", {cout4, sum4}, 5'b0_1000);

        // Abort on the second SHIFT edge
        a4 = 4'h7; b4 = 4'h7; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        check("abort_idle", {busy4, done4}, 2'b00);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done4) ndone++; end
        check("abort_no_done", ndone, 0);
        check("abort_sum_hold", {cout4, sum4}, 5'b0_1000);

        // Abort on the terminal shift edge beats the transition to DONE
        a4 = 4'h1; b4 = 4'h1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick(); tick(); tick();
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        check("abort_last_idle", {busy4, done4}, 2'b00);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (done4) ndone++; end
        check("abort_last_no_done", ndone, 0);
        check("abort_last_sum_hold", {cout4, sum4}, 5'b0_1000);

        // abort together with start in IDLE: start wins
        run_op4(4'h2, 4'h3, 1'b1, 4'h5, 1'b0, "abort_in_idle");

        // Asynchronous reset mid-SHIFT
        a4 = 4'h3; b4 = 4'h4; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("rst_pre_busy", busy4, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {busy4, done4, cout4, sum4}, '0);
        tick();
        check("rst_held_outputs", {busy4, done4, cout4, sum4}, '0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (done4 || busy4) ndone++; end
        check("rst_no_done", ndone, 0);
        run_op4(4'h6, 4'h7, 1'b0, 4'hD, 1'b0, "post_rst_op");

        // Randomized traffic
        do_reset();
        rand_run(4, 200, 1'b0);
        do_reset();
        rand_run(8, 200, 1'b0);
        do_reset();
        rand_run(4, 60, 1'b1);
        do_reset();
        rand_run(8, 60, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width and number of serial add steps; WIDTH SHALL be >= 2.
REQ-002 Port: clk  input  1  clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a new addition; sampled on rising clk.
REQ-005 Port: abort  input  1  synchronous cancel of an addition in progress.
REQ-006 Port: a  input  WIDTH  augend; captured only on accepted start.
REQ-007 Port: b  input  WIDTH  addend; captured only on accepted start.
REQ-008 Port: busy  output  1  high whenever state != IDLE.
REQ-009 Port: done  output  1  one-cycle completion pulse.
REQ-010 Port: sum  output  WIDTH  result of last completed addition.
REQ-011 Port: cout  output  1  carry-out of last completed addition.

Function
REQ-012 The block SHALL contain its own datapath: WIDTH-bit A shift register, WIDTH-bit B shift register, 1-bit full adder on A[0], B[0], carry; 1-bit carry register; step counter of ceil(log2(WIDTH)) bits.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE, with no other reachable states.
REQ-014 IDLE: on an edge with start=1, SHALL load A<=a, B<=b, carry<=0, count<=0, and go to SHIFT; start=0 stays in IDLE.
REQ-015 SHIFT, each edge: A <= {fa_sum, A[WIDTH-1:1]}, B <= {0, B[WIDTH-1:1]}, carry <= fa_carry, count <= count+1.
REQ-016 SHIFT: on the edge where count == WIDTH-1 (the WIDTH-th shift), the state SHALL go to DONE, and sum<=next A and cout<=next carry SHALL be registered on that same edge.
REQ-017 DONE: done=1 for exactly one cycle; the next edge SHALL go to IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th rising edge counted from, and including, the start-accepting edge; WIDTH=4 gives 5 edges.
REQ-019 start while in SHIFT or DONE SHALL be ignored, with no queuing and no operand capture; a, b changes outside the accepting edge SHALL have no effect.
REQ-020 Back-to-back: start held high SHALL be accepted on the first IDLE edge after DONE, giving a throughput of one addition per WIDTH+2 cycles.
REQ-021 abort=1 in SHIFT SHALL return to IDLE on that edge, with no done pulse and sum/cout unchanged; abort in IDLE or DONE SHALL have no effect; abort has priority over the count terminal transition.
REQ-022 abort=1 together with start=1 in IDLE: start SHALL be accepted, since abort is ignored in IDLE.
REQ-023 sum and cout SHALL change only on the REQ-016 edge and on reset, and SHALL hold stable through IDLE and subsequent SHIFT cycles.
REQ-024 Arithmetic: {cout,sum} SHALL equal a+b taken modulo 2^(WIDTH+1), unsigned.
REQ-025 done and busy SHALL be registered or decoded from state only, never from start or abort combinationally.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, count=0, A=0, B=0, independent of clk.
REQ-027 Reset asserted mid-SHIFT SHALL discard the operation, with no done pulse.
REQ-028 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=4, a=1001, b=0111, start pulse -> busy for 5 cycles; done in cycle after the 5th edge; sum=0000, cout=1.
REQ-030 a=0101, b=0010 then immediately a=1111, b=0001 with start held high -> first done shows sum=0111, cout=0; second start accepted on the next IDLE edge; second done shows sum=0000, cout=1.
REQ-031 Start pulses during SHIFT and during DONE, with a, b changed to 0000 -> ignored; result equals the originally captured operands; exactly one done.
REQ-032 abort on the 2nd SHIFT edge -> IDLE next cycle, no done, sum/cout still hold the previous result.
REQ-033 rst_n low mid-SHIFT, asynchronous between edges -> all outputs 0 immediately; no done; a new start after release completes correctly.
REQ-034 Randomised a, b over 200 operations, with WIDTH=4 and WIDTH=8 -> {cout,sum} == a+b each done; done count == accepted start count.
